// File: rtl/i2s_pcm.sv
// i2s_pcm: I2S master receiver for the PCM1808, generating SCKI/BCK/LRCK from clk
// and deserialising DOUT into 24-bit left/right samples with a per-frame strobe.
module i2s_pcm (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        din_i,
  output logic        bck_o,
  output logic        lrck_o,
  output logic        scki_o,
  output logic [23:0] left_o,
  output logic [23:0] right_o,
  output logic        newsample_valid_o
);
  logic [8:0]  cnt_q, cnt_d;
  logic [1:0]  sync_q;
  logic [23:0] lsr_q, lsr_d, rsr_q, rsr_d;
  logic [23:0] left_q, left_d, right_q, right_d;
  logic        valid_q, valid_d;
  logic [4:0]  slot;
  logic        take, wrap;
  always_comb begin
    cnt_d   = cnt_q + 9'd1;
    slot    = cnt_q[7:3];
    take    = (cnt_q[2:0] == 3'b101) && (slot >= 5'd1) && (slot <= 5'd24);
    wrap    = &cnt_q;
    lsr_d   = (take && !cnt_q[8]) ? {lsr_q[22:0], sync_q[1]} : lsr_q;
    rsr_d   = (take &&  cnt_q[8]) ? {rsr_q[22:0], sync_q[1]} : rsr_q;
    left_d  = wrap ? lsr_q : left_q;
    right_d = wrap ? rsr_q : right_q;
    valid_d = wrap;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q   <= '0;
      sync_q  <= '0;
      lsr_q   <= '0;
      rsr_q   <= '0;
      left_q  <= '0;
      right_q <= '0;
      valid_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      sync_q  <= {sync_q[0], din_i};
      lsr_q   <= lsr_d;
      rsr_q   <= rsr_d;
      left_q  <= left_d;
      right_q <= right_d;
      valid_q <= valid_d;
    end
  end
  assign scki_o            = cnt_q[0];
  assign bck_o             = cnt_q[2];
  assign lrck_o            = cnt_q[8];
  assign left_o            = left_q;
  assign right_o           = right_q;
  assign newsample_valid_o = valid_q;
endmodule

// File: tb/tb_i2s_pcm.sv
// tb_i2s_pcm: randomized frame-level bench for i2s_pcm; din is generated from per-frame
// sample tables and strobes are compared against the frame arithmetic (strobe at 512*(f+1)).
module tb_i2s_pcm;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        din = 1'b0;
  logic        bck, lrck, scki, valid;
  logic [23:0] left, right;
  int          tests = 0;
  int          fails = 0;
  int          k;
  int          chg;
  logic [23:0] fl [8];
  logic [23:0] fr [8];
  logic [23:0] pl, pr;
  int          sk [$];
  logic [23:0] sl [$];
  logic [23:0] sr [$];

  i2s_pcm dut (
    .clk_i(clk), .rst_ni(rst_n), .din_i(din), .bck_o(bck), .lrck_o(lrck), .scki_o(scki),
    .left_o(left), .right_o(right), .newsample_valid_o(valid)
  );

  always #5 clk = ~clk;

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    k = 0; chg = 0; pl = '0; pr = '0;
    sk.delete(); sl.delete(); sr.delete();
  endtask

  // One iteration per negedge while the DUT counter equals k mod 512; din follows frame tables.
  task automatic drive(input int stop_k, input bit ign_one);
    logic [8:0]  cc;
    logic [23:0] w;
    int          slot;
    while (k <= stop_k) begin
      if (k > 0 && valid === 1'b1) begin
        sk.push_back(k); sl.push_back(left); sr.push_back(right);
      end else if (left !== pl || right !== pr) chg++;
      pl = left; pr = right;
      cc = k[8:0];
      slot = int'(cc[7:3]);
      w = cc[8] ? fr[(k / 512) % 8] : fl[(k / 512) % 8];
      din = (slot >= 1 && slot <= 24) ? w[24 - slot] : (ign_one ? 1'b1 : 1'($urandom % 2));
      @(negedge clk);
      k++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (4) begin
      @(negedge clk);
      tests++;
      if ({scki, bck, lrck, valid, left, right} !== '0) begin
        fails++;
        $display("FAIL reset_state got %b%b%b%b %h %h exp all zero", scki, bck, lrck, valid, left, right);
      end
    end
  endtask

  task automatic test_clock();
    logic [8:0] cc;
    int bad = 0;
    apply_reset();
    din = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      cc = i[8:0];
      tests++;
      if ({lrck, bck, scki} !== {cc[8], cc[2], cc[0]}) begin
        fails++;
        if (bad++ < 5) $display("FAIL clock_div k=%0d got lrck/bck/scki=%b%b%b exp %b%b%b", i, lrck, bck, scki, cc[8], cc[2], cc[0]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_basic();
    apply_reset();
    fl[0] = 24'hA5A5A5; fr[0] = 24'h123456;
    drive(515, 1'b0);
    tests++;
    if (sk.size() !== 1) begin
      fails++; $display("FAIL basic_count got %0d strobes exp 1", sk.size());
    end else begin
      tests += 3;
      if (sk[0] !== 512) begin fails++; $display("FAIL basic_time got %0d exp 512", sk[0]); end
      if (sl[0] !== 24'hA5A5A5) begin fails++; $display("FAIL basic_left got %h exp a5a5a5", sl[0]); end
      if (sr[0] !== 24'h123456) begin fails++; $display("FAIL basic_right got %h exp 123456", sr[0]); end
    end
  endtask

  task automatic test_ignored();
    apply_reset();
    fl[0] = 24'($urandom) | 24'h1; fr[0] = 24'($urandom) | 24'h1;
    fl[1] = '0; fr[1] = '0;
    drive(1025, 1'b1);
    tests++;
    if (sk.size() !== 2) begin
      fails++; $display("FAIL ignored_count got %0d strobes exp 2", sk.size());
    end else begin
      tests += 2;
      if ({sl[0], sr[0]} !== {fl[0], fr[0]}) begin fails++; $display("FAIL ignored_pre got %h %h exp %h %h", sl[0], sr[0], fl[0], fr[0]); end
      if ({sl[1], sr[1]} !== 48'h0) begin fails++; $display("FAIL ignored_zero got %h %h exp 0 0", sl[1], sr[1]); end
    end
  endtask

  task automatic test_fullscale();
    apply_reset();
    fl[0] = 24'h800000; fr[0] = 24'h7FFFFF;
    fl[1] = 24'hFFFFFF; fr[1] = 24'h000000;
    drive(1100, 1'b0);
    tests += 2;
    if (chg !== 0) begin fails++; $display("FAIL fullscale_hold got %0d changes exp 0", chg); end
    if (sk.size() !== 2) begin
      fails++; $display("FAIL fullscale_count got %0d strobes exp 2", sk.size());
    end else begin
      for (int i = 0; i < 2; i++) begin
        tests++;
        if ({sk[i], sl[i], sr[i]} !== {512 * (i + 1), fl[i], fr[i]}) begin
          fails++; $display("FAIL fullscale_%0d got k=%0d %h %h exp k=%0d %h %h", i, sk[i], sl[i], sr[i], 512 * (i + 1), fl[i], fr[i]);
        end
      end
    end
  endtask

  task automatic test_midreset();
    apply_reset();
    fl[0] = 24'($urandom) | 24'h800000; fr[0] = 24'($urandom) | 24'h1;
    fl[1] = 24'($urandom); fr[1] = 24'($urandom);
    drive(811, 1'b0);
    tests++;
    if (sl.size() !== 1 || sl[0] !== fl[0] || sr[0] !== fr[0]) begin
      fails++; $display("FAIL midreset_pre got %0d strobes exp 1 with %h %h", sl.size(), fl[0], fr[0]);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if ({valid, left, right, lrck, bck, scki} !== '0) begin
      fails++; $display("FAIL midreset_clear got %b %h %h exp 0 0 0", valid, left, right);
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    k = 0; chg = 0; pl = '0; pr = '0;
    sk.delete(); sl.delete(); sr.delete();
    fl[0] = ~fl[1]; fr[0] = ~fr[1];
    drive(520, 1'b0);
    tests++;
    if (sk.size() !== 1) begin
      fails++; $display("FAIL midreset_count got %0d strobes exp 1", sk.size());
    end else begin
      tests++;
      if ({sk[0], sl[0], sr[0]} !== {512, fl[0], fr[0]}) begin
        fails++; $display("FAIL midreset_post got k=%0d %h %h exp k=512 %h %h", sk[0], sl[0], sr[0], fl[0], fr[0]);
      end
    end
  endtask

  task automatic test_stream();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      fl[i] = 24'($urandom) ^ 24'(i); fr[i] = 24'($urandom) ^ 24'(i << 8);
    end
    drive(2100, 1'b0);
    tests += 2;
    if (chg !== 0) begin fails++; $display("FAIL stream_hold got %0d changes exp 0", chg); end
    if (sk.size() !== 4) begin
      fails++; $display("FAIL stream_count got %0d strobes exp 4", sk.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests++;
        if ({sk[i], sl[i], sr[i]} !== {512 * (i + 1), fl[i], fr[i]}) begin
          fails++; $display("FAIL stream_%0d got k=%0d %h %h exp k=%0d %h %h", i, sk[i], sl[i], sr[i], 512 * (i + 1), fl[i], fr[i]);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_clock();
    test_basic();
    test_ignored();
    test_fullscale();
    test_midreset();
    test_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
